// File: rtl/ir_sensor_sweep.sv
// SPI master that sweeps the 8 IR line-sensor channels of an ADC128S-style A2D into a regfile.
// Optional feature macro: IR_GATE_EN (IR emitter gated per sweep, with a settle delay before ch0).
module ir_sensor_sweep #(
   parameter int unsigned SCLK_W     = 5,
   parameter int unsigned GAP_CYC    = 32,
   parameter int unsigned SETTLE_CYC = 1024
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic        strt,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        IR_EN,
   output logic        busy,
   output logic        sweep_done,
   input  logic [2:0]  rd_chnl,
   output logic [11:0] rd_data
);

   localparam int unsigned CH_W    = 3;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned NUM_CH  = 8;
   localparam int unsigned HALF    = 2 ** (SCLK_W - 1);
   localparam int unsigned TXN_CYC = (2 * WORD_W + 1) * HALF;
   localparam int unsigned MAX_TG  = (TXN_CYC > GAP_CYC) ? TXN_CYC : GAP_CYC;
   localparam int unsigned CNT_MAX = (MAX_TG > SETTLE_CYC) ? MAX_TG : SETTLE_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
`ifdef IR_GATE_EN
   localparam logic IR_RST = 1'b0;
`else
   localparam logic IR_RST = 1'b1;
`endif

   typedef enum logic [2:0] {IDLE, SETTLE, SEL, GAP1, READ, GAP2, DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt, tick_pos;
   logic [CH_W-1:0]     ch, ch_nxt, go_ch;
   logic [WORD_W-1:0]   tx, tx_nxt;
   logic [DATA_W-1:0]   rx, rx_nxt;
   logic                ss_n_nxt, sclk_nxt, ir_en_nxt, busy_nxt, done_nxt;
   logic                go, wr_en, sclk_tick, sclk_fall;
   logic [DATA_W-1:0]   regs [NUM_CH];

   // MOSI is the MSB of the command shift register, so it updates only on the shifting falls
   assign MOSI      = tx[WORD_W-1];
   assign tick_pos  = cnt + CNT_W'(1);
   assign sclk_tick = ((tick_pos & CNT_W'(HALF - 1)) == '0) &&
                      (tick_pos >= CNT_W'(HALF)) &&
                      (tick_pos <= CNT_W'(2 * WORD_W * HALF));
   assign sclk_fall = (tick_pos & CNT_W'(HALF)) != '0;

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      ch_nxt    = ch;
      tx_nxt    = tx;
      rx_nxt    = rx;
      ss_n_nxt  = SS_n;
      sclk_nxt  = SCLK;
      ir_en_nxt = IR_EN;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      wr_en     = 1'b0;
      go        = 1'b0;
      go_ch     = ch;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (strt) begin
               busy_nxt = 1'b1;
               ch_nxt   = '0;
               go_ch    = '0;
`ifdef IR_GATE_EN
               state_nxt = SETTLE;
               ir_en_nxt = 1'b1;
`else
               state_nxt = SEL;
               go        = 1'b1;
`endif
            end
         end
         SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
               state_nxt = SEL;
               go        = 1'b1;
            end
         end
         SEL, READ: begin
            if (tick_pos == CNT_W'(TXN_CYC)) begin
               ss_n_nxt  = 1'b1;
               cnt_nxt   = '0;
               wr_en     = (state == READ);
               state_nxt = (state == SEL) ? GAP1 : GAP2;
            end else if (sclk_tick) begin
               sclk_nxt = ~sclk_fall;
               // first fall leaves cmd[15] on MOSI; later falls shift
               if (!sclk_fall) begin
                  rx_nxt = {rx[DATA_W-2:0], MISO};
               end else if (tick_pos >= CNT_W'(3 * HALF)) begin
                  tx_nxt = {tx[WORD_W-2:0], 1'b0};
               end
            end
         end
         GAP1: begin
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
               state_nxt = READ;
               go        = 1'b1;
            end
         end
         GAP2: begin
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
               if (ch == CH_W'(NUM_CH - 1)) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
`ifdef IR_GATE_EN
                  ir_en_nxt = 1'b0;
`endif
               end else begin
                  ch_nxt    = ch + CH_W'(1);
                  go_ch     = ch + CH_W'(1);
                  state_nxt = SEL;
                  go        = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: state_nxt = IDLE;
      endcase

      // Open a transaction: drop SS_n and load the command word for go_ch
      if (go) begin
         ss_n_nxt = 1'b0;
         cnt_nxt  = '0;
         tx_nxt   = {2'b00, go_ch, 11'h000};
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state      <= IDLE;
         cnt        <= '0;
         ch         <= '0;
         tx         <= '0;
         rx         <= '0;
         SS_n       <= 1'b1;
         SCLK       <= 1'b1;
         IR_EN      <= IR_RST;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ch         <= ch_nxt;
         tx         <= tx_nxt;
         rx         <= rx_nxt;
         SS_n       <= ss_n_nxt;
         SCLK       <= sclk_nxt;
         IR_EN      <= ir_en_nxt;
         busy       <= busy_nxt;
         sweep_done <= done_nxt;
      end
   end

   // Result regfile; rx holds the low 12 bits of the READ word when SS_n rises
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            regs[i] <= '1;
         end
      end else if (wr_en) begin
         regs[ch] <= rx;
      end
   end

   assign rd_data = regs[rd_chnl];

endmodule

// File: tb/tb_ir_sensor_sweep.sv
// Scoreboard bench for ir_sensor_sweep with an ADC128S-style slave model.
`timescale 1ns/1ps
module tb_ir_sensor_sweep;

`ifdef IR_GATE_EN
   localparam int unsigned SETTLE     = 1024;
   localparam logic        IR_RST_EXP = 1'b0;
`else
   localparam int unsigned SETTLE     = 0;
   localparam logic        IR_RST_EXP = 1'b1;
`endif
   localparam int unsigned SWEEP_LAT = 8960 + SETTLE;
   localparam int unsigned TXN_LEN   = 528;

   logic        clk = 1'b0;
   logic        RST_n, strt, MISO, SS_n, SCLK, MOSI, IR_EN, busy, sweep_done;
   logic [2:0]  rd_chnl;
   logic [11:0] rd_data;

   ir_sensor_sweep dut (
      .clk(clk), .RST_n(RST_n), .strt(strt), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
      .MOSI(MOSI), .IR_EN(IR_EN), .busy(busy), .sweep_done(sweep_done),
      .rd_chnl(rd_chnl), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [11:0] data_tab [8] = '{12'h000, 12'h101, 12'h202, 12'h303,
                                 12'h404, 12'h505, 12'h606, 12'h707};
   logic [15:0] cmd_tab [8]  = '{16'h0000, 16'h0800, 16'h1000, 16'h1800,
                                 16'h2000, 16'h2800, 16'h3000, 16'h3800};

   typedef struct { logic [15:0] cmd; int unsigned rises; int unsigned len; } txn_t;
   typedef struct { int unsigned lat; logic [95:0] vals; } sweep_t;

   txn_t        txn_q [$];
   sweep_t      sweep_q [$];
   logic [95:0] rf_q [$];

   int unsigned checks = 0, failures = 0;
   int unsigned start_cyc = 0, done_cnt = 0, ss_falls = 0, idle_toggles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event not matched by scoreboard at %0t", name, $time);
   endtask

   // ADC128S-style slave: channel chosen by one transaction is returned in the next
   logic        lp = 1'b0;
   logic [15:0] sl_sh = '0, sl_cmd = '0;
   int unsigned sl_falls = 0, sl_rises = 0;
   logic [2:0]  sl_ch = '0;

   function automatic logic [15:0] slave_word(input logic [2:0] c);
      logic [11:0] d;
      d = lp ? (12'(c) * 12'h101) : 12'hFFF;
      return {4'h5, d};
   endfunction

   assign MISO = sl_sh[15];
   always @(negedge SS_n) begin
      sl_sh = slave_word(sl_ch);
      sl_falls = 0;
      sl_rises = 0;
   end
   always @(negedge SCLK) if (!SS_n) begin
      if (sl_falls > 0) sl_sh = {sl_sh[14:0], 1'b0};
      sl_falls++;
   end
   always @(posedge SCLK) if (!SS_n) begin
      sl_cmd = {sl_cmd[14:0], MOSI};
      sl_rises++;
   end
   always @(posedge SS_n) if (sl_rises == 16) sl_ch = sl_cmd[13:11];

   // Transaction monitor: MOSI word, SCLK rise count and SS_n low time per transaction
   logic        ss_prev = 1'b1, sclk_prev = 1'b1;
   int unsigned fall_cyc = 0, mon_rises = 0;
   logic [15:0] mon_cmd = '0;
   txn_t        cur_t;
   always @(negedge clk) begin
      if (!RST_n) begin
         ss_prev   = 1'b1;
         sclk_prev = 1'b1;
      end else begin
         if (ss_prev && !SS_n) begin
            fall_cyc  = cyc;
            mon_rises = 0;
            mon_cmd   = '0;
            ss_falls++;
         end else if (!ss_prev && !SS_n && !sclk_prev && SCLK) begin
            mon_cmd = {mon_cmd[14:0], MOSI};
            mon_rises++;
         end else if (ss_prev && SS_n && (SCLK != sclk_prev)) begin
            idle_toggles++;
         end
         if (!ss_prev && SS_n) begin
            if (txn_q.size() == 0) miss("txn_unexpected");
            else begin
               cur_t = txn_q.pop_front();
               chk("mosi_cmd", 32'(mon_cmd), 32'(cur_t.cmd));
               chk("sclk_rises", mon_rises, cur_t.rises);
               chk("ss_low_len", cyc - fall_cyc, cur_t.len);
               chk("sclk_high_at_ss_rise", 32'(SCLK), 32'd1);
            end
         end
         ss_prev   = SS_n;
         sclk_prev = SCLK;
      end
   end

   // Sweep-done and regfile checker: sole driver of rd_chnl
   sweep_t      cur_sw;
   logic [95:0] rd_exp;
   logic        rd_pend = 1'b0;
   always @(negedge clk) begin
      if (RST_n && sweep_done) begin
         done_cnt++;
         if (sweep_q.size() == 0) miss("sweep_done_unexpected");
         else begin
            cur_sw = sweep_q.pop_front();
            chk("sweep_latency", cyc - start_cyc, cur_sw.lat);
            chk("busy_at_done", 32'(busy), 32'd0);
`ifdef IR_GATE_EN
            chk("ir_en_at_done", 32'(IR_EN), 32'd0);
`endif
            rd_exp  = cur_sw.vals;
            rd_pend = 1'b1;
         end
      end else if (rf_q.size() > 0) begin
         rd_exp  = rf_q.pop_front();
         rd_pend = 1'b1;
      end
      if (rd_pend) begin
         for (int c = 0; c < 8; c++) begin
            rd_chnl = 3'(c);
            #1;
            chk($sformatf("rd_data[%0d]", c), 32'(rd_data), 32'(rd_exp[c*12 +: 12]));
         end
         rd_pend = 1'b0;
      end
   end

   function automatic logic [95:0] all_fff();
      return {8{12'hFFF}};
   endfunction

   task automatic start_sweep(input logic mode);
      txn_t   t;
      sweep_t s;
      lp = mode;
      for (int c = 0; c < 8; c++) begin
         t.cmd = cmd_tab[c];
         t.rises = 16;
         t.len = TXN_LEN;
         txn_q.push_back(t);
         txn_q.push_back(t);
         s.vals[c*12 +: 12] = mode ? data_tab[c] : 12'hFFF;
      end
      s.lat = SWEEP_LAT;
      sweep_q.push_back(s);
      @(negedge clk) strt = 1'b1;
      @(negedge clk) strt = 1'b0;
      start_cyc = cyc;
      chk("busy_after_strt", 32'(busy), 32'd1);
`ifdef IR_GATE_EN
      chk("ir_en_after_strt", 32'(IR_EN), 32'd1);
      repeat (SETTLE - 1) @(negedge clk);
      chk("ss_n_during_settle", 32'(SS_n), 32'd1);
      @(negedge clk);
`endif
      chk("ss_n_first_fall", 32'(SS_n), 32'd0);
   endtask

   task automatic wait_done();
      int unsigned n0, k;
      n0 = done_cnt;
      k  = 0;
      while (done_cnt == n0 && k < SWEEP_LAT + 200) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == n0) miss("sweep_done_timeout");
      repeat (3) @(negedge clk);
   endtask

   int unsigned d0, s0, target;

   initial begin
      RST_n = 1'b0; strt = 1'b0; rd_chnl = '0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd1);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sweep_done", 32'(sweep_done), 32'd0);
      chk("rst_ir_en", 32'(IR_EN), 32'(IR_RST_EXP));
      rf_q.push_back(all_fff());
      repeat (3) @(negedge clk);
      RST_n = 1'b1;
      repeat (5) @(negedge clk);

      // No line present, plus a strt landing on the sweep_done clk
      d0 = done_cnt;
      start_sweep(1'b0);
      target = start_cyc + SWEEP_LAT - 1;
      while (cyc < target) @(negedge clk);
      strt = 1'b1;
      @(negedge clk) strt = 1'b0;
      repeat (3) @(negedge clk);
      s0 = ss_falls;
      repeat (100) @(negedge clk);
      chk("strt_on_done_busy", 32'(busy), 32'd0);
      chk("strt_on_done_no_txn", ss_falls, s0);
      chk("sweep1_done_count", done_cnt - d0, 32'd1);

      // Per-channel data sweep
      start_sweep(1'b1);
      wait_done();

      // Reset at t=300 of ch2 READ
      start_sweep(1'b1);
      target = start_cyc + SETTLE + 2800 + 300 - SETTLE * 0;
      target = start_cyc + 2800 + 300;
`ifdef IR_GATE_EN
      target = start_cyc + SETTLE + 2800 + 300;
`endif
      while (cyc < target) @(negedge clk);
      #2;
      chk("pre_abort_ss_n", 32'(SS_n), 32'd0);
      txn_q.delete();
      sweep_q.delete();
      RST_n = 1'b0;
      #1;
      chk("abort_ss_n", 32'(SS_n), 32'd1);
      chk("abort_sclk", 32'(SCLK), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      rf_q.push_back(all_fff());
      repeat (3) @(negedge clk);
      RST_n = 1'b1;
      repeat (5) @(negedge clk);

      // Second strt 100 clk into a sweep must be ignored
      d0 = done_cnt;
      start_sweep(1'b1);
      repeat (99) @(negedge clk);
      strt = 1'b1;
      @(negedge clk) strt = 1'b0;
      wait_done();
      repeat (200) @(negedge clk);
      chk("sweep5_done_count", done_cnt - d0, 32'd1);
      chk("txn_q_drained", 32'(txn_q.size()), 32'd0);
      chk("sclk_idle_toggles", idle_toggles, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
